// File: rtl/collatz_sweep.sv
// Caller-side sweep controller: drives one collatz core over an inclusive input
// range and reports the peak result, the earliest input producing it, and the call count.
module collatz_sweep #(
  parameter int W = 32
) (
  input  logic         ap_clk,
  input  logic         ap_rst,
  input  logic         ap_start,
  output logic         ap_done,
  output logic         ap_idle,
  output logic         ap_ready,
  input  logic [W-1:0] ap_lo,
  input  logic [W-1:0] ap_hi,
  output logic [W-1:0] ap_return,
  output logic [W-1:0] ap_argmax,
  output logic [W:0]   ap_count,
  output logic         c_start,
  output logic [W-1:0] c_n,
  input  logic         c_done,
  input  logic         c_idle,
  input  logic [W-1:0] c_return
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_FINISH = 3'd3
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] cur_q, cur_d;
  logic [W-1:0] hi_q, hi_d;
  logic [W-1:0] max_q, max_d;
  logic [W-1:0] arg_q, arg_d;
  logic [W:0]   cnt_q, cnt_d;

  logic         ap_done_d, ap_ready_d, c_start_d;
  logic [W-1:0] ap_return_d, ap_argmax_d, c_n_d;
  logic [W:0]   ap_count_d;

  assign ap_idle = (state_q == S_IDLE);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q   <= S_IDLE;
      cur_q     <= '0;
      hi_q      <= '0;
      max_q     <= '0;
      arg_q     <= '0;
      cnt_q     <= '0;
      ap_done   <= 1'b0;
      ap_ready  <= 1'b1;
      ap_return <= '0;
      ap_argmax <= '0;
      ap_count  <= '0;
      c_start   <= 1'b0;
      c_n       <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      hi_q      <= hi_d;
      max_q     <= max_d;
      arg_q     <= arg_d;
      cnt_q     <= cnt_d;
      ap_done   <= ap_done_d;
      ap_ready  <= ap_ready_d;
      ap_return <= ap_return_d;
      ap_argmax <= ap_argmax_d;
      ap_count  <= ap_count_d;
      c_start   <= c_start_d;
      c_n       <= c_n_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    hi_d        = hi_q;
    max_d       = max_q;
    arg_d       = arg_q;
    cnt_d       = cnt_q;
    ap_done_d   = ap_done;
    ap_ready_d  = ap_ready;
    ap_return_d = ap_return;
    ap_argmax_d = ap_argmax;
    ap_count_d  = ap_count;
    c_start_d   = c_start;
    c_n_d       = c_n;

    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          cur_d      = ap_lo;
          hi_d       = ap_hi;
          max_d      = '0;
          cnt_d      = '0;
          arg_d      = ap_lo;
          ap_done_d  = 1'b0;
          ap_ready_d = 1'b0;
          if (ap_lo > ap_hi) begin
            state_d = S_FINISH;
          end else begin
            c_n_d     = ap_lo;
            c_start_d = 1'b1;
            state_d   = S_ISSUE;
          end
        end
      end

      // Callee dropping idle is the only proof it took this call; until then
      // any done it shows belongs to the previous call.
      S_ISSUE: begin
        c_start_d = 1'b1;
        if (!c_idle) begin
          c_start_d = 1'b0;
          state_d   = S_WAIT;
        end
      end

      // End test precedes the increment so hi = all-ones never wraps.
      S_WAIT: begin
        if (c_done && c_idle) begin
          cnt_d = cnt_q + 1'b1;
          if (c_return > max_q) begin
            max_d = c_return;
            arg_d = cur_q;
          end
          if (cur_q == hi_q) begin
            state_d = S_FINISH;
          end else begin
            cur_d     = cur_q + 1'b1;
            c_n_d     = cur_q + 1'b1;
            c_start_d = 1'b1;
            state_d   = S_ISSUE;
          end
        end
      end

      S_FINISH: begin
        ap_return_d = max_q;
        ap_argmax_d = arg_q;
        ap_count_d  = cnt_q;
        ap_done_d   = 1'b1;
        ap_ready_d  = 1'b1;
        state_d     = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        c_start_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_collatz_sweep.sv
// Bench for collatz_sweep: a W=32 instance against a behavioural collatz callee and a
// W=8 instance against an identity stub; results are checked against a range-sweep model.
module tb_collatz_sweep;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // W=32 instance and its callee
  logic        s32, d32, i32, r32, cs32, cd32, ci32;
  logic [31:0] lo32, hi32, ret32, arg32, cn32, cr32;
  logic [32:0] cnt32;

  // W=8 instance and its stub callee
  logic        s8, d8, i8, r8, cs8, cd8, ci8;
  logic [7:0]  lo8, hi8, ret8, arg8, cn8, cr8;
  logic [8:0]  cnt8;

  collatz_sweep #(.W(32)) u32 (
    .ap_clk(clk), .ap_rst(rst), .ap_start(s32), .ap_done(d32), .ap_idle(i32),
    .ap_ready(r32), .ap_lo(lo32), .ap_hi(hi32), .ap_return(ret32), .ap_argmax(arg32),
    .ap_count(cnt32), .c_start(cs32), .c_n(cn32), .c_done(cd32), .c_idle(ci32),
    .c_return(cr32)
  );

  collatz_sweep #(.W(8)) u8 (
    .ap_clk(clk), .ap_rst(rst), .ap_start(s8), .ap_done(d8), .ap_idle(i8),
    .ap_ready(r8), .ap_lo(lo8), .ap_hi(hi8), .ap_return(ret8), .ap_argmax(arg8),
    .ap_count(cnt8), .c_start(cs8), .c_n(cn8), .c_done(cd8), .c_idle(ci8),
    .c_return(cr8)
  );

  int checks = 0;
  int passed = 0;

  // Peak value reached along the trajectory from n down to 1 (n itself excluded).
  function automatic logic [31:0] peak(input logic [31:0] n);
    longint x, p;
    x = longint'(n);
    p = 0;
    while (x > 1) begin
      if (x % 2 == 0) x = x / 2;
      else            x = 3 * x + 1;
      if (x > p) p = x;
    end
    return p[31:0];
  endfunction

  function automatic void ref_sweep(input longint lo, input longint hi,
                                    output longint mx, output longint arg,
                                    output longint cnt);
    longint p;
    mx = 0; arg = lo; cnt = 0;
    for (longint n = lo; n <= hi; n++) begin
      p = longint'(peak(n[31:0]));
      cnt++;
      if (p > mx) begin mx = p; arg = n; end
    end
  endfunction

  // Behavioural collatz callee, latency 2..4 cycles depending on n
  logic        busy32;
  int          left32;
  logic [31:0] nlat32;
  int          calls32 = 0;
  logic [31:0] calln_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ci32 <= 1'b1; cd32 <= 1'b0; cr32 <= '0; busy32 <= 1'b0; left32 <= 0; nlat32 <= '0;
    end else if (busy32) begin
      if (left32 == 0) begin
        busy32 <= 1'b0; ci32 <= 1'b1; cd32 <= 1'b1; cr32 <= peak(nlat32);
      end else begin
        left32 <= left32 - 1;
      end
    end else if (cs32) begin
      busy32 <= 1'b1; ci32 <= 1'b0; cd32 <= 1'b0; nlat32 <= cn32;
      left32 <= 1 + int'(cn32 % 3);
      calls32 <= calls32 + 1;
      calln_q.push_back(cn32);
    end
  end

  // Identity stub, fixed 3-cycle latency
  logic       busy8;
  int         left8;
  logic [7:0] nlat8;
  int         calls8 = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ci8 <= 1'b1; cd8 <= 1'b0; cr8 <= '0; busy8 <= 1'b0; left8 <= 0; nlat8 <= '0;
    end else if (busy8) begin
      if (left8 == 0) begin
        busy8 <= 1'b0; ci8 <= 1'b1; cd8 <= 1'b1; cr8 <= nlat8;
      end else begin
        left8 <= left8 - 1;
      end
    end else if (cs8) begin
      busy8 <= 1'b1; ci8 <= 1'b0; cd8 <= 1'b0; nlat8 <= cn8; left8 <= 2;
      calls8 <= calls8 + 1;
    end
  end

  // c_start pulse widths in cycles
  int run32 = 0;
  int pulse_q[$];
  always @(negedge clk) begin
    if (cs32 === 1'b1) run32 = run32 + 1;
    else if (run32 != 0) begin
      pulse_q.push_back(run32);
      run32 = 0;
    end
  end

  task automatic run32_sweep(input logic [31:0] lo, input logic [31:0] hi, output bit tmo);
    @(negedge clk);
    lo32 = lo; hi32 = hi; s32 = 1'b1;
    @(posedge clk);
    #1 s32 = 1'b0;
    tmo = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (d32 === 1'b1) begin tmo = 1'b0; break; end
    end
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({r32, d32, i32, cs32} !== 4'b1010) $display("FAIL reset_ctrl ready/done/idle/c_start=%b expected 1010", {r32, d32, i32, cs32});
    else passed++;
    checks++;
    if ({ret32, arg32, cnt32} !== 97'd0) $display("FAIL reset_data return=%0d argmax=%0d count=%0d expected 0", ret32, arg32, cnt32);
    else passed++;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_sweep_1_7;
    bit tmo;
    int bq, bp;
    bq = calln_q.size(); bp = pulse_q.size();
    run32_sweep(32'd1, 32'd7, tmo);
    checks++;
    if (tmo) $display("FAIL sweep17_timeout no ap_done within budget");
    else passed++;
    checks++;
    if ({ret32, arg32, cnt32} !== {32'd52, 32'd7, 33'd7})
      $display("FAIL sweep17 return=%0d argmax=%0d count=%0d expected 52/7/7", ret32, arg32, cnt32);
    else passed++;
    checks++;
    if (calln_q.size() - bq !== 7) $display("FAIL sweep17_calls got %0d expected 7", calln_q.size() - bq);
    else passed++;
    for (int k = 0; k < 7 && bq + k < calln_q.size(); k++) begin
      checks++;
      if (calln_q[bq + k] !== 32'(k + 1)) $display("FAIL sweep17_cn[%0d] got %0d expected %0d", k, calln_q[bq + k], k + 1);
      else passed++;
    end
    for (int k = bp; k < pulse_q.size(); k++) begin
      checks++;
      if (pulse_q[k] !== 2) $display("FAIL sweep17_pulse[%0d] width %0d expected 2", k - bp, pulse_q[k]);
      else passed++;
    end
  endtask

  task automatic test_tie;
    bit tmo;
    run32_sweep(32'd3, 32'd6, tmo);
    checks++;
    if (tmo || {ret32, arg32, cnt32} !== {32'd16, 32'd3, 33'd4})
      $display("FAIL tie tmo=%0d return=%0d argmax=%0d count=%0d expected 16/3/4", tmo, ret32, arg32, cnt32);
    else passed++;
  endtask

  task automatic test_single;
    bit tmo;
    run32_sweep(32'd1, 32'd1, tmo);
    checks++;
    if (tmo || {ret32, arg32, cnt32} !== {32'd0, 32'd1, 33'd1})
      $display("FAIL single tmo=%0d return=%0d argmax=%0d count=%0d expected 0/1/1", tmo, ret32, arg32, cnt32);
    else passed++;
  endtask

  task automatic test_empty;
    int bc, bp;
    bc = calls32; bp = pulse_q.size();
    @(negedge clk);
    lo32 = 32'd5; hi32 = 32'd4; s32 = 1'b1;
    @(posedge clk);
    #1 s32 = 1'b0;
    checks++;
    if ({d32, r32, cs32} !== 3'b000) $display("FAIL empty_accept done/ready/c_start=%b expected 000", {d32, r32, cs32});
    else passed++;
    @(posedge clk);
    #1;
    checks++;
    if ({d32, r32, i32} !== 3'b111) $display("FAIL empty_done done/ready/idle=%b expected 111", {d32, r32, i32});
    else passed++;
    checks++;
    if ({ret32, arg32, cnt32} !== {32'd0, 32'd5, 33'd0})
      $display("FAIL empty_result return=%0d argmax=%0d count=%0d expected 0/5/0", ret32, arg32, cnt32);
    else passed++;
    repeat (3) @(negedge clk);
    checks++;
    if (calls32 - bc !== 0 || pulse_q.size() - bp !== 0)
      $display("FAIL empty_nocall calls=%0d pulses=%0d expected 0", calls32 - bc, pulse_q.size() - bp);
    else passed++;
  endtask

  task automatic test_wrap;
    bit tmo;
    int bc;
    bc = calls8;
    @(negedge clk);
    lo8 = 8'd254; hi8 = 8'd255; s8 = 1'b1;
    @(posedge clk);
    #1 s8 = 1'b0;
    tmo = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (d8 === 1'b1) begin tmo = 1'b0; break; end
    end
    checks++;
    if (tmo || {ret8, arg8, cnt8} !== {8'd255, 8'd255, 9'd2})
      $display("FAIL wrap tmo=%0d return=%0d argmax=%0d count=%0d expected 255/255/2", tmo, ret8, arg8, cnt8);
    else passed++;
    repeat (20) @(negedge clk);
    checks++;
    if (calls8 - bc !== 2 || i8 !== 1'b1)
      $display("FAIL wrap_stop calls=%0d idle=%b expected 2 and 1", calls8 - bc, i8);
    else passed++;
  endtask

  task automatic test_random;
    bit tmo;
    logic [31:0] lo, hi;
    longint mx, arg, cnt;
    for (int t = 0; t < 10; t++) begin
      lo = $urandom_range(1, 300);
      if ($urandom_range(0, 4) == 0) hi = lo - 1 - $urandom_range(0, int'(lo) - 1);
      else hi = lo + $urandom_range(0, 10);
      ref_sweep(longint'(lo), longint'(hi), mx, arg, cnt);
      run32_sweep(lo, hi, tmo);
      checks++;
      if (tmo || ret32 !== mx[31:0] || arg32 !== arg[31:0] || cnt32 !== cnt[32:0])
        $display("FAIL random[%0d] lo=%0d hi=%0d tmo=%0d got %0d/%0d/%0d expected %0d/%0d/%0d",
                 t, lo, hi, tmo, ret32, arg32, cnt32, mx, arg, cnt);
      else passed++;
    end
  endtask

  task automatic test_start_held;
    int bc, accepts, idle_twice;
    bit prev_idle, tmo;
    bc = calls32; accepts = 0; idle_twice = 0; prev_idle = 1'b1;
    @(negedge clk);
    lo32 = 32'd2; hi32 = 32'd4; s32 = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (prev_idle && i32 === 1'b0) accepts++;
      if (prev_idle && i32 === 1'b1) idle_twice++;
      prev_idle = i32;
    end
    s32 = 1'b0;
    tmo = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i32 === 1'b1) begin tmo = 1'b0; break; end
    end
    checks++;
    if (tmo || accepts < 2) $display("FAIL held_accepts tmo=%0d accepts=%0d expected >=2", tmo, accepts);
    else passed++;
    checks++;
    if (idle_twice !== 0) $display("FAIL held_idle_linger count=%0d expected 0", idle_twice);
    else passed++;
    checks++;
    if (calls32 - bc !== 3 * accepts) $display("FAIL held_calls got %0d expected %0d", calls32 - bc, 3 * accepts);
    else passed++;
    checks++;
    if ({d32, ret32, arg32, cnt32} !== {1'b1, 32'd16, 32'd3, 33'd3})
      $display("FAIL held_result done=%b return=%0d argmax=%0d count=%0d expected 1/16/3/3", d32, ret32, arg32, cnt32);
    else passed++;
  endtask

  task automatic test_rst_midsweep;
    bit tmo, seen;
    longint mx, arg, cnt;
    @(negedge clk);
    lo32 = 32'd1; hi32 = 32'd7; s32 = 1'b1;
    @(posedge clk);
    #1 s32 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cs32 === 1'b0 && i32 === 1'b0 && ci32 === 1'b0) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) $display("FAIL rst_wait_reach callee never busy");
    else passed++;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({r32, d32, i32, cs32} !== 4'b1010) $display("FAIL rst_mid_ctrl ready/done/idle/c_start=%b expected 1010", {r32, d32, i32, cs32});
    else passed++;
    checks++;
    if ({ret32, arg32, cnt32, cn32} !== 129'd0)
      $display("FAIL rst_mid_data return=%0d argmax=%0d count=%0d c_n=%0d expected 0", ret32, arg32, cnt32, cn32);
    else passed++;
    @(negedge clk) rst = 1'b0;
    ref_sweep(2, 5, mx, arg, cnt);
    run32_sweep(32'd2, 32'd5, tmo);
    checks++;
    if (tmo || ret32 !== mx[31:0] || arg32 !== arg[31:0] || cnt32 !== cnt[32:0])
      $display("FAIL rst_recover tmo=%0d got %0d/%0d/%0d expected %0d/%0d/%0d", tmo, ret32, arg32, cnt32, mx, arg, cnt);
    else passed++;
  endtask

  initial begin
    s32 = 1'b0; lo32 = '0; hi32 = '0;
    s8 = 1'b0;  lo8 = '0;  hi8 = '0;
    test_reset();
    test_sweep_1_7();
    test_tie();
    test_single();
    test_empty();
    test_wrap();
    test_random();
    test_start_held();
    test_rst_midsweep();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
